// File: rtl/adc_pll_reset_seq.sv
// Reset sequencer for the ADC PLL: holds the PLL in reset, qualifies lock, then releases the
// 4-phase capture logic. Retries on lock timeout and latches an error after repeated failure.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// PLL_RST  0  | pll_rst held high for RST_HOLD cycles
// WAIT_LOCK 1 | pll_rst low, waiting up to LOCK_TIMEOUT cycles for lock
// STABLE   2  | lock seen; must stay locked for STABLE_CYCLES cycles
// RUN      3  | capture logic released, watching for lock loss
// FAIL     4  | retries exhausted; only soft_reset or rst_n leave
module adc_pll_reset_seq #(
   parameter int RST_HOLD      = 16,
   parameter int LOCK_TIMEOUT  = 20000,
   parameter int STABLE_CYCLES = 256,
   parameter int RETRY_MAX     = 3
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       soft_reset,
   output logic       pll_rst,
   output logic       adc_rst_n,
   output logic       ready,
   output logic       fail,
   output logic [7:0] relock_count,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_PLL_RST   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAIL      = 3'd4
   } state_e;

   localparam logic [15:0] RST_LAST    = 16'(RST_HOLD - 1);
   localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
   localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
   localparam logic [3:0]  RETRY_LIM   = 4'(RETRY_MAX);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  retry_q, retry_d;
   logic [7:0]  relock_q, relock_d;
   logic        sync1_q, lk_q;
   logic        pll_rst_q, pll_rst_d;
   logic        adc_rst_n_q, adc_rst_n_d;
   logic        ready_q, ready_d;
   logic        fail_q, fail_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      retry_d  = retry_q;
      relock_d = relock_q;
      // soft_reset wins over any lock event seen in the same cycle
      if (soft_reset) begin
         state_d = S_PLL_RST;
         cnt_d   = '0;
         retry_d = '0;
      end else begin
         case (state_q)
            S_PLL_RST: begin
               if (cnt_q == RST_LAST) begin
                  state_d = S_WAIT_LOCK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            S_WAIT_LOCK: begin
               if (lk_q) begin
                  state_d = S_STABLE;
                  cnt_d   = '0;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  cnt_d = '0;
                  if (retry_q < RETRY_LIM) begin
                     retry_d = retry_q + 4'd1;
                     state_d = S_PLL_RST;
                  end else begin
                     state_d = S_FAIL;
                  end
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            S_STABLE: begin
               if (!lk_q) begin
                  state_d = S_WAIT_LOCK;
                  cnt_d   = '0;
               end else if (cnt_q == STABLE_LAST) begin
                  state_d = S_RUN;
                  cnt_d   = '0;
                  retry_d = '0;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            S_RUN: begin
               if (!lk_q) begin
                  state_d = S_PLL_RST;
                  cnt_d   = '0;
                  if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
               end
            end
            S_FAIL: ;
            default: begin
               state_d = S_PLL_RST;
               cnt_d   = '0;
            end
         endcase
      end

      // outputs follow the state being entered so they change on the entry edge
      pll_rst_d   = (state_d == S_PLL_RST) || (state_d == S_FAIL);
      adc_rst_n_d = (state_d == S_RUN);
      ready_d     = (state_d == S_RUN);
      fail_d      = (state_d == S_FAIL);
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_PLL_RST;
         cnt_q       <= '0;
         retry_q     <= '0;
         relock_q    <= '0;
         sync1_q     <= 1'b0;
         lk_q        <= 1'b0;
         pll_rst_q   <= 1'b1;
         adc_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         relock_q    <= relock_d;
         sync1_q     <= pll_locked;
         lk_q        <= sync1_q;
         pll_rst_q   <= pll_rst_d;
         adc_rst_n_q <= adc_rst_n_d;
         ready_q     <= ready_d;
         fail_q      <= fail_d;
      end
   end

   assign pll_rst      = pll_rst_q;
   assign adc_rst_n    = adc_rst_n_q;
   assign ready        = ready_q;
   assign fail         = fail_q;
   assign relock_count = relock_q;
   assign state        = state_q;

endmodule

// File: tb/tb_adc_pll_reset_seq.sv
// Scoreboard bench for adc_pll_reset_seq: expectations are queued as stimulus is applied and
// popped when the corresponding output is sampled, 1 time unit after the rising edge.
module tb_adc_pll_reset_seq;

   logic       refclk = 1'b0;
   logic       rst_n;
   logic       pll_locked;
   logic       soft_reset;
   logic       pll_rst;
   logic       adc_rst_n;
   logic       ready;
   logic       fail;
   logic [7:0] relock_count;
   logic [2:0] state;

   adc_pll_reset_seq #(
      .RST_HOLD(4), .LOCK_TIMEOUT(100), .STABLE_CYCLES(8), .RETRY_MAX(2)
   ) dut (
      .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .soft_reset(soft_reset),
      .pll_rst(pll_rst), .adc_rst_n(adc_rst_n), .ready(ready), .fail(fail),
      .relock_count(relock_count), .state(state)
   );

   always #5 refclk = ~refclk;

   typedef struct {
      string tag;
      int    val;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   exp_relock = 0;

   task automatic chk(input string tag, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic exp_push(input string tag, input int val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic chk_pop(input int act);
      exp_t e;
      if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL sb_underflow: got %0d, no expectation queued", act);
      end else begin
         e = sb.pop_front();
         chk(e.tag, act, e.val);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge refclk);
      #1;
   endtask

   task automatic wait_ready(input string tag, input int max);
      int c = 0;
      while (ready !== 1'b1 && c < max) begin
         tick(1);
         c++;
      end
      chk(tag, ready, 1);
   endtask

   task automatic wait_state(input string tag, input int s, input int max);
      int c = 0;
      while (state !== 3'(s) && c < max) begin
         tick(1);
         c++;
      end
      chk(tag, state, s);
   endtask

   task automatic push_reset_vals(input string pfx);
      exp_push({pfx, "_pll_rst"}, 1);
      exp_push({pfx, "_adc_rst_n"}, 0);
      exp_push({pfx, "_ready"}, 0);
      exp_push({pfx, "_fail"}, 0);
      exp_push({pfx, "_relock"}, 0);
      exp_push({pfx, "_state"}, 0);
   endtask

   task automatic pop_all_outputs();
      chk_pop(pll_rst);
      chk_pop(adc_rst_n);
      chk_pop(ready);
      chk_pop(fail);
      chk_pop(relock_count);
      chk_pop(state);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got t=%0t, want < 2ms", $time);
      $fatal(1);
   end

   initial begin
      rst_n      = 1'b0;
      pll_locked = 1'b0;
      soft_reset = 1'b0;

      // 1: reset values, PLL reset hold, first lock
      #23;
      push_reset_vals("rst");
      pop_all_outputs();
      rst_n = 1'b1;
      exp_push("t1_hold", 1);
      tick(3);
      chk_pop(pll_rst);
      exp_push("t1_pll_rst_low", 0);
      exp_push("t1_wait_state", 1);
      tick(1);
      chk_pop(pll_rst);
      chk_pop(state);
      tick(16);
      pll_locked = 1'b1;
      exp_push("t1_ready_early", 0);
      exp_push("t1_stable_state", 2);
      tick(10);
      chk_pop(ready);
      chk_pop(state);
      exp_push("t1_ready", 1);
      exp_push("t1_adc_rst_n", 1);
      exp_push("t1_run_state", 3);
      exp_push("t1_fail", 0);
      tick(1);
      chk_pop(ready);
      chk_pop(adc_rst_n);
      chk_pop(state);
      chk_pop(fail);

      // 2: lock dropout during STABLE
      soft_reset = 1'b1;
      exp_push("t2_soft_state", 0);
      exp_push("t2_soft_ready", 0);
      tick(1);
      soft_reset = 1'b0;
      chk_pop(state);
      chk_pop(ready);
      exp_push("t2_in_stable", 2);
      tick(5);
      chk_pop(state);
      pll_locked = 1'b0;
      exp_push("t2_back_wait", 1);
      exp_push("t2_adc_held", 0);
      tick(3);
      chk_pop(state);
      chk_pop(adc_rst_n);
      pll_locked = 1'b1;
      exp_push("t2_adc_early", 0);
      tick(10);
      chk_pop(adc_rst_n);
      exp_push("t2_adc_release", 1);
      tick(1);
      chk_pop(adc_rst_n);

      // 3: lock loss in RUN
      pll_locked = 1'b0;
      exp_push("t3_adc_still_1", 1);
      tick(2);
      chk_pop(adc_rst_n);
      exp_relock = (exp_relock < 255) ? exp_relock + 1 : 255;
      exp_push("t3_adc_low", 0);
      exp_push("t3_pll_rst", 1);
      exp_push("t3_state", 0);
      exp_push("t3_relock", exp_relock);
      tick(1);
      chk_pop(adc_rst_n);
      chk_pop(pll_rst);
      chk_pop(state);
      chk_pop(relock_count);
      exp_push("t3_hold_last", 1);
      tick(3);
      chk_pop(pll_rst);
      exp_push("t3_hold_end", 0);
      tick(1);
      chk_pop(pll_rst);
      pll_locked = 1'b1;
      exp_push("t3_relock_ready_early", 0);
      tick(10);
      chk_pop(ready);
      exp_push("t3_relock_ready", 1);
      tick(1);
      chk_pop(ready);

      // 4: no lock -> three timed-out attempts -> FAIL
      pll_locked = 1'b0;
      exp_relock = (exp_relock < 255) ? exp_relock + 1 : 255;
      exp_push("t4_enter_rst", 0);
      exp_push("t4_relock", exp_relock);
      tick(3);
      chk_pop(state);
      chk_pop(relock_count);
      exp_push("t4_retry1_rst", 0);
      exp_push("t4_retry1_pll_rst", 1);
      tick(104);
      chk_pop(state);
      chk_pop(pll_rst);
      exp_push("t4_last_wait", 1);
      exp_push("t4_no_fail_yet", 0);
      tick(207);
      chk_pop(state);
      chk_pop(fail);
      exp_push("t4_fail_state", 4);
      exp_push("t4_fail", 1);
      exp_push("t4_fail_pll_rst", 1);
      exp_push("t4_fail_adc", 0);
      tick(1);
      chk_pop(state);
      chk_pop(fail);
      chk_pop(pll_rst);
      chk_pop(adc_rst_n);
      exp_push("t4_fail_sticky", 4);
      tick(50);
      chk_pop(state);
      soft_reset = 1'b1;
      exp_push("t4_soft_state", 0);
      exp_push("t4_soft_fail", 0);
      tick(1);
      soft_reset = 1'b0;
      chk_pop(state);
      chk_pop(fail);

      // 5: soft_reset coincident with lock loss, then relock_count saturation
      pll_locked = 1'b1;
      wait_ready("t5_lock", 40);
      pll_locked = 1'b0;
      tick(2);
      soft_reset = 1'b1;
      exp_push("t5_soft_state", 0);
      exp_push("t5_soft_relock", exp_relock);
      tick(1);
      soft_reset = 1'b0;
      chk_pop(state);
      chk_pop(relock_count);
      for (int i = 0; i < 256; i++) begin
         pll_locked = 1'b1;
         wait_ready("t5_loop_ready", 40);
         pll_locked = 1'b0;
         tick(3);
         exp_relock = (exp_relock < 255) ? exp_relock + 1 : 255;
         if (i == 0) begin
            exp_push("t5_first_loss", exp_relock);
            chk_pop(relock_count);
         end
      end
      exp_push("t5_saturated", exp_relock);
      chk_pop(relock_count);

      // 6: async reset mid-STABLE and mid-WAIT_LOCK
      pll_locked = 1'b1;
      wait_state("t6_reach_stable", 2, 40);
      #1 rst_n = 1'b0;
      exp_relock = 0;
      push_reset_vals("t6a");
      #1 pop_all_outputs();
      #1 rst_n = 1'b1;
      pll_locked = 1'b0;
      exp_push("t6_wait_state", 1);
      tick(4);
      chk_pop(state);
      tick(10);
      rst_n = 1'b0;
      push_reset_vals("t6b");
      #1 pop_all_outputs();
      #1 rst_n = 1'b1;
      exp_push("t6_restart_hold_end", 0);
      tick(4);
      chk_pop(pll_rst);
      pll_locked = 1'b1;
      exp_push("t6_restart_ready", 1);
      exp_push("t6_restart_state", 3);
      exp_push("t6_restart_relock", 0);
      tick(11);
      chk_pop(ready);
      chk_pop(state);
      chk_pop(relock_count);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
